// File: rtl/ahb_axi_pkg.sv
// Shared encodings for the AHB-Lite <-> AXI3 bridges.
//   - AHB HTRANS / HRESP codes
//   - AXI BURST / RESP codes
//   - state enum of the AHB-to-AXI bridge FSM
package ahb_axi_pkg;

   localparam logic [1:0] HtransIdle   = 2'd0;
   localparam logic [1:0] HtransBusy   = 2'd1;
   localparam logic [1:0] HtransNonseq = 2'd2;
   localparam logic [1:0] HtransSeq    = 2'd3;

   localparam logic [1:0] HrespOkay  = 2'd0;
   localparam logic [1:0] HrespError = 2'd1;

   localparam logic [1:0] AxiBurstFixed = 2'b00;
   localparam logic [1:0] AxiBurstIncr  = 2'b01;

   localparam logic [1:0] AxiRespOkay   = 2'b00;
   localparam logic [1:0] AxiRespExokay = 2'b01;
   localparam logic [1:0] AxiRespSlverr = 2'b10;
   localparam logic [1:0] AxiRespDecerr = 2'b11;

   typedef enum logic [3:0] {
      StIdle,
      StWdata,
      StWreq,
      StWrsp,
      StRreq,
      StRrsp,
      StDone,
      StErr1,
      StErr2
   } bridge_state_e;

endpackage

// File: rtl/ahb2axi_strb_gen.sv
// Write-strobe generator: AHB transfer size and low address bits to a
// 32-bit AXI byte-lane strobe.
//   hsize  in  3 : AHB HSIZE (0 byte, 1 half, 2 word)
//   addr   in  2 : haddr[1:0]
//   wstrb  out 4 : byte lane enables
module ahb2axi_strb_gen (
   input  logic [2:0] hsize,
   input  logic [1:0] addr,
   output logic [3:0] wstrb
);

   always_comb begin
      wstrb = 4'hF;
      case (hsize)
         3'd0:    wstrb = 4'b0001 << addr;
         3'd1:    wstrb = 4'b0011 << {addr[1], 1'b0};
         default: wstrb = 4'hF;
      endcase
   end

endmodule

// File: rtl/ahb2axi_bridge.sv
// AHB-Lite slave to AXI3 master bridge. Each accepted AHB transfer becomes one
// single-beat AXI transaction; the AHB data phase is stretched with
// ahb_hreadyout low until the AXI response returns. One transaction in flight.
//   clk, rst_n         : clock, async active-low reset
//   ahb_*              : AHB-Lite slave port (hburst not used)
//   axi_aw*/w*/b*      : AXI3 write channels (master side)
//   axi_ar*/r*         : AXI3 read channels (master side)
// All non-constant outputs come straight from flops.
module ahb2axi_bridge
   import ahb_axi_pkg::*;
#(
   parameter logic [7:0]  AXI_ID = 8'h00,
   parameter int unsigned W_ADDR = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   // AHB-Lite slave
   input  logic              ahb_hsel,
   input  logic [W_ADDR-1:0] ahb_haddr,
   input  logic [1:0]        ahb_htrans,
   input  logic              ahb_hwrite,
   input  logic [2:0]        ahb_hsize,
   input  logic [31:0]       ahb_hwdata,
   input  logic              ahb_hready,
   output logic              ahb_hreadyout,
   output logic [1:0]        ahb_hresp,
   output logic [31:0]       ahb_hrdata,
   // AXI write address
   output logic [7:0]        axi_awid,
   output logic [W_ADDR-1:0] axi_awaddr,
   output logic [7:0]        axi_awlen,
   output logic [2:0]        axi_awsize,
   output logic [1:0]        axi_awburst,
   output logic              axi_awvalid,
   input  logic              axi_awready,
   // AXI write data
   output logic [7:0]        axi_wid,
   output logic [31:0]       axi_wdata,
   output logic [3:0]        axi_wstrb,
   output logic              axi_wlast,
   output logic              axi_wvalid,
   input  logic              axi_wready,
   // AXI write response
   input  logic [7:0]        axi_bid,
   input  logic [1:0]        axi_bresp,
   input  logic              axi_bvalid,
   output logic              axi_bready,
   // AXI read address
   output logic [7:0]        axi_arid,
   output logic [W_ADDR-1:0] axi_araddr,
   output logic [7:0]        axi_arlen,
   output logic [2:0]        axi_arsize,
   output logic [1:0]        axi_arburst,
   output logic              axi_arvalid,
   input  logic              axi_arready,
   // AXI read data
   input  logic [7:0]        axi_rid,
   input  logic [31:0]       axi_rdata,
   input  logic [1:0]        axi_rresp,
   input  logic              axi_rlast,
   input  logic              axi_rvalid,
   output logic              axi_rready
);

   bridge_state_e     state_q, state_d;
   logic              hreadyout_q;
   logic [1:0]        hresp_q;
   logic [31:0]       hrdata_q;
   logic [W_ADDR-1:0] addr_q;
   logic [2:0]        size_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic              awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;

   logic              accept;
   logic [3:0]        wstrb_nxt;
   logic              unused;

   // Response ID/last and the EXOKAY bit carry no information for a single
   // outstanding single-beat transaction.
   assign unused = ^{axi_bid, axi_rid, axi_rlast, axi_bresp[0], axi_rresp[0]};

   assign accept = ahb_hsel & ahb_htrans[1] & ahb_hready & hreadyout_q;

   ahb2axi_strb_gen u_strb_gen (
      .hsize (ahb_hsize),
      .addr  (ahb_haddr[1:0]),
      .wstrb (wstrb_nxt)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         // Every state with hreadyout high can take a new address phase.
         StIdle, StDone, StErr2: begin
            state_d = StIdle;
            if (accept) begin
               if (ahb_hsize > 3'd2)  state_d = StErr1;
               else if (ahb_hwrite)   state_d = StWdata;
               else                   state_d = StRreq;
            end
         end
         StWdata: state_d = StWreq;
         StWreq: begin
            // AW and W complete independently; leave once both are done.
            if ((!awvalid_q || axi_awready) && (!wvalid_q || axi_wready)) state_d = StWrsp;
         end
         StWrsp: if (axi_bvalid) state_d = axi_bresp[1] ? StErr1 : StDone;
         StRreq: if (axi_arready) state_d = StRrsp;
         StRrsp: if (axi_rvalid) state_d = axi_rresp[1] ? StErr1 : StDone;
         StErr1: state_d = StErr2;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         hreadyout_q <= 1'b1;
         hresp_q     <= HrespOkay;
         hrdata_q    <= '0;
         addr_q      <= '0;
         size_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         hreadyout_q <= (state_d == StIdle) || (state_d == StDone) || (state_d == StErr2);
         hresp_q     <= ((state_d == StErr1) || (state_d == StErr2)) ? HrespError : HrespOkay;
         // Valids are raised entering WREQ and each held until its own ready.
         awvalid_q   <= (state_q == StWdata) || (awvalid_q && !axi_awready);
         wvalid_q    <= (state_q == StWdata) || (wvalid_q && !axi_wready);
         arvalid_q   <= (state_d == StRreq);
         bready_q    <= (state_d == StWrsp);
         rready_q    <= (state_d == StRrsp);
         if (accept) begin
            addr_q  <= ahb_haddr;
            size_q  <= ahb_hsize;
            wstrb_q <= wstrb_nxt;
         end
         if (state_q == StWdata) wdata_q <= ahb_hwdata;
         if (state_q == StRrsp && axi_rvalid) hrdata_q <= axi_rdata;
      end
   end

   assign ahb_hreadyout = hreadyout_q;
   assign ahb_hresp     = hresp_q;
   assign ahb_hrdata    = hrdata_q;

   assign axi_awid    = AXI_ID;
   assign axi_awaddr  = addr_q;
   assign axi_awlen   = 8'd0;
   assign axi_awsize  = size_q;
   assign axi_awburst = AxiBurstIncr;
   assign axi_awvalid = awvalid_q;

   assign axi_wid    = AXI_ID;
   assign axi_wdata  = wdata_q;
   assign axi_wstrb  = wstrb_q;
   assign axi_wlast  = wvalid_q;
   assign axi_wvalid = wvalid_q;

   assign axi_bready = bready_q;

   assign axi_arid    = AXI_ID;
   assign axi_araddr  = addr_q;
   assign axi_arlen   = 8'd0;
   assign axi_arsize  = size_q;
   assign axi_arburst = AxiBurstIncr;
   assign axi_arvalid = arvalid_q;

   assign axi_rready = rready_q;

endmodule

// File: tb/tb_ahb2axi_bridge.sv
// Directed bench for ahb2axi_bridge. Inputs change and outputs are sampled
// 1 time unit after the rising edge.
module tb_ahb2axi_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ahb_hsel;
   logic [31:0] ahb_haddr;
   logic [1:0]  ahb_htrans;
   logic        ahb_hwrite;
   logic [2:0]  ahb_hsize;
   logic [31:0] ahb_hwdata;
   logic        ahb_hready;
   logic        ahb_hreadyout;
   logic [1:0]  ahb_hresp;
   logic [31:0] ahb_hrdata;
   logic [7:0]  axi_awid, axi_wid, axi_arid, axi_awlen, axi_arlen, axi_bid, axi_rid;
   logic [31:0] axi_awaddr, axi_araddr, axi_wdata, axi_rdata;
   logic [2:0]  axi_awsize, axi_arsize;
   logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
   logic [3:0]  axi_wstrb;
   logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
   logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
   logic        axi_rlast, axi_rvalid, axi_rready;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ahb2axi_bridge dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ahb_hsel      (ahb_hsel),
      .ahb_haddr     (ahb_haddr),
      .ahb_htrans    (ahb_htrans),
      .ahb_hwrite    (ahb_hwrite),
      .ahb_hsize     (ahb_hsize),
      .ahb_hwdata    (ahb_hwdata),
      .ahb_hready    (ahb_hready),
      .ahb_hreadyout (ahb_hreadyout),
      .ahb_hresp     (ahb_hresp),
      .ahb_hrdata    (ahb_hrdata),
      .axi_awid      (axi_awid),
      .axi_awaddr    (axi_awaddr),
      .axi_awlen     (axi_awlen),
      .axi_awsize    (axi_awsize),
      .axi_awburst   (axi_awburst),
      .axi_awvalid   (axi_awvalid),
      .axi_awready   (axi_awready),
      .axi_wid       (axi_wid),
      .axi_wdata     (axi_wdata),
      .axi_wstrb     (axi_wstrb),
      .axi_wlast     (axi_wlast),
      .axi_wvalid    (axi_wvalid),
      .axi_wready    (axi_wready),
      .axi_bid       (axi_bid),
      .axi_bresp     (axi_bresp),
      .axi_bvalid    (axi_bvalid),
      .axi_bready    (axi_bready),
      .axi_arid      (axi_arid),
      .axi_araddr    (axi_araddr),
      .axi_arlen     (axi_arlen),
      .axi_arsize    (axi_arsize),
      .axi_arburst   (axi_arburst),
      .axi_arvalid   (axi_arvalid),
      .axi_arready   (axi_arready),
      .axi_rid       (axi_rid),
      .axi_rdata     (axi_rdata),
      .axi_rresp     (axi_rresp),
      .axi_rlast     (axi_rlast),
      .axi_rvalid    (axi_rvalid),
      .axi_rready    (axi_rready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                             input logic [1:0] tr);
      ahb_haddr  = a;
      ahb_hwrite = wr;
      ahb_hsize  = sz;
      ahb_htrans = tr;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      ahb_hsel = 1'b1; ahb_hready = 1'b1; ahb_hwdata = '0;
      addr_phase(32'h0, 1'b0, 3'd0, 2'd0);
      axi_awready = 1'b1; axi_wready = 1'b1; axi_arready = 1'b1;
      axi_bid = 8'h5A; axi_bresp = 2'b00; axi_bvalid = 1'b0;
      axi_rid = 8'hA5; axi_rdata = '0; axi_rresp = 2'b00; axi_rlast = 1'b1; axi_rvalid = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_hreadyout", 32'(ahb_hreadyout), 32'd1);
      chk("rst_hresp", 32'(ahb_hresp), 32'd0);
      chk("rst_hrdata", ahb_hrdata, 32'd0);
      chk("rst_valids", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}, 32'd0);
      chk("rst_awaddr", axi_awaddr, 32'd0);
      chk("rst_wdata", axi_wdata, 32'd0);
      chk("rst_wstrb", 32'(axi_wstrb), 32'd0);
      rst_n = 1'b1;
      tick();

      // Word write 0x3100 <- 0xDEADBEEF, zero-latency AXI
      axi_bvalid = 1'b1;
      addr_phase(32'h3100, 1'b1, 3'd2, 2'd2);
      tick();                                          // WDATA
      addr_phase(32'h0, 1'b0, 3'd0, 2'd0);
      ahb_hwdata = 32'hDEADBEEF;
      chk("wr_wait1", 32'(ahb_hreadyout), 32'd0);
      tick();                                          // WREQ
      chk("wr_wait2", 32'(ahb_hreadyout), 32'd0);
      chk("wr_aw_w_valid", {axi_awvalid, axi_wvalid, axi_wlast}, 32'b111);
      chk("wr_awaddr", axi_awaddr, 32'h3100);
      chk("wr_wdata", axi_wdata, 32'hDEADBEEF);
      chk("wr_wstrb", 32'(axi_wstrb), 32'hF);
      chk("wr_awsize", 32'(axi_awsize), 32'd2);
      chk("wr_awlen_burst_id", {axi_awlen, 6'd0, axi_awburst, axi_awid}, 32'h0001_00);
      tick();                                          // WRSP
      chk("wr_wait3", 32'(ahb_hreadyout), 32'd0);
      chk("wr_valids_low", {axi_awvalid, axi_wvalid, axi_bready}, 32'b001);
      tick();                                          // DONE
      chk("wr_done_ready", 32'(ahb_hreadyout), 32'd1);
      chk("wr_done_hresp", 32'(ahb_hresp), 32'd0);
      chk("wr_done_bready", 32'(axi_bready), 32'd0);
      axi_bvalid = 1'b0;
      tick();                                          // IDLE

      // Byte read at 0x3202
      axi_rvalid = 1'b1; axi_rdata = 32'h00AB0000;
      addr_phase(32'h3202, 1'b0, 3'd0, 2'd2);
      tick();                                          // RREQ
      addr_phase(32'h0, 1'b0, 3'd0, 2'd0);
      chk("rd_wait1", 32'(ahb_hreadyout), 32'd0);
      chk("rd_arvalid", 32'(axi_arvalid), 32'd1);
      chk("rd_araddr", axi_araddr, 32'h3202);
      chk("rd_arsize", 32'(axi_arsize), 32'd0);
      chk("rd_arlen_burst_id", {axi_arlen, 6'd0, axi_arburst, axi_arid}, 32'h0001_00);
      tick();                                          // RRSP
      chk("rd_wait2", 32'(ahb_hreadyout), 32'd0);
      chk("rd_ar_r", {axi_arvalid, axi_rready}, 32'b01);
      tick();                                          // DONE
      chk("rd_done_ready", 32'(ahb_hreadyout), 32'd1);
      chk("rd_hrdata", ahb_hrdata, 32'h00AB0000);
      chk("rd_hresp", 32'(ahb_hresp), 32'd0);
      axi_rvalid = 1'b0;
      tick();

      // Staggered AW/W: halfword write at 0x3406, EXOKAY response
      axi_awready = 1'b0; axi_wready = 1'b0;
      addr_phase(32'h3406, 1'b1, 3'd1, 2'd2);
      tick();                                          // WDATA
      addr_phase(32'h0, 1'b0, 3'd0, 2'd0);
      ahb_hwdata = 32'h12345678;
      tick();                                          // WREQ, no readies
      chk("stg_wstrb", 32'(axi_wstrb), 32'hC);
      chk("stg_both_valid", {axi_awvalid, axi_wvalid, axi_bready}, 32'b110);
      tick();
      chk("stg_both_valid2", {axi_awvalid, axi_wvalid, axi_bready}, 32'b110);
      axi_wready = 1'b1;
      tick();                                          // W handshake done
      chk("stg_w_dropped", {axi_awvalid, axi_wvalid, axi_bready}, 32'b100);
      axi_wready = 1'b0;
      tick();
      chk("stg_aw_held", {axi_awvalid, axi_wvalid, axi_bready}, 32'b100);
      axi_awready = 1'b1;
      tick();                                          // AW handshake -> WRSP
      chk("stg_bready", {axi_awvalid, axi_wvalid, axi_bready}, 32'b001);
      tick();                                          // bvalid still low
      chk("stg_b_wait", {31'd0, ahb_hreadyout}, 32'd0);
      axi_bvalid = 1'b1; axi_bresp = 2'b01;
      tick();
      chk("stg_exokay", {ahb_hreadyout, ahb_hresp}, 32'b100);
      axi_bvalid = 1'b0; axi_bresp = 2'b00; axi_wready = 1'b1;
      tick();

      // SLVERR on B -> two-cycle ERROR
      axi_bvalid = 1'b1; axi_bresp = 2'b10;
      addr_phase(32'h3500, 1'b1, 3'd2, 2'd2);
      tick();
      addr_phase(32'h0, 1'b0, 3'd0, 2'd0);
      tick(); tick(); tick();                          // ERR1
      chk("berr_cycle1", {ahb_hreadyout, ahb_hresp}, 32'b001);
      axi_bvalid = 1'b0; axi_bresp = 2'b00;
      tick();                                          // ERR2
      chk("berr_cycle2", {ahb_hreadyout, ahb_hresp}, 32'b101);
      tick();
      chk("berr_idle", {ahb_hreadyout, ahb_hresp}, 32'b100);

      // hsize=3 -> ERROR without any AXI activity
      addr_phase(32'h3508, 1'b1, 3'd3, 2'd2);
      tick();
      addr_phase(32'h0, 1'b0, 3'd0, 2'd0);
      chk("szerr_cycle1", {ahb_hreadyout, ahb_hresp}, 32'b001);
      chk("szerr_noaxi1", {axi_awvalid, axi_wvalid, axi_arvalid}, 32'b000);
      tick();
      chk("szerr_cycle2", {ahb_hreadyout, ahb_hresp}, 32'b101);
      chk("szerr_noaxi2", {axi_awvalid, axi_wvalid, axi_arvalid}, 32'b000);
      tick();

      // Back-to-back: NONSEQ write, SEQ read accepted in DONE
      axi_bvalid = 1'b1;
      addr_phase(32'h3600, 1'b1, 3'd2, 2'd2);
      tick();
      addr_phase(32'h0, 1'b0, 3'd0, 2'd0);
      ahb_hwdata = 32'hCAFEF00D;
      tick(); tick(); tick();                          // DONE
      chk("b2b_done", 32'(ahb_hreadyout), 32'd1);
      axi_bvalid = 1'b0;
      addr_phase(32'h3604, 1'b0, 3'd2, 2'd3);
      tick();                                          // straight to RREQ
      addr_phase(32'h0, 1'b0, 3'd0, 2'd0);
      chk("b2b_arvalid", {axi_arvalid, ahb_hreadyout}, 32'b10);
      chk("b2b_araddr", axi_araddr, 32'h3604);
      axi_rvalid = 1'b1; axi_rdata = 32'h55AA1234;
      tick(); tick();                                  // DONE
      chk("b2b_rdata", ahb_hrdata, 32'h55AA1234);
      chk("b2b_rd_done", 32'(ahb_hreadyout), 32'd1);
      axi_rvalid = 1'b0;
      tick();
      chk("idle_zero_wait1", {ahb_hreadyout, ahb_hresp, axi_arvalid}, 32'b1000);
      tick();
      chk("idle_zero_wait2", {ahb_hreadyout, ahb_hresp, axi_awvalid}, 32'b1000);

      // Reset while in WRSP
      addr_phase(32'h3700, 1'b1, 3'd2, 2'd2);
      tick();
      addr_phase(32'h0, 1'b0, 3'd0, 2'd0);
      ahb_hwdata = 32'h11112222;
      tick(); tick();                                  // WRSP
      chk("mid_wrsp", {axi_bready, ahb_hreadyout}, 32'b10);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {ahb_hreadyout, ahb_hresp, axi_bready}, 32'b1000);
      chk("mid_rst_hrdata", ahb_hrdata, 32'd0);
      chk("mid_rst_regs", axi_awaddr ^ axi_wdata ^ 32'(axi_wstrb), 32'd0);
      chk("mid_rst_wdata", axi_wdata, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      axi_rvalid = 1'b1; axi_rdata = 32'h0BADF00D;
      addr_phase(32'h3800, 1'b0, 3'd2, 2'd2);
      tick();
      addr_phase(32'h0, 1'b0, 3'd0, 2'd0);
      chk("post_rst_arvalid", 32'(axi_arvalid), 32'd1);
      tick(); tick();
      chk("post_rst_rdata", ahb_hrdata, 32'h0BADF00D);
      chk("post_rst_done", {ahb_hreadyout, ahb_hresp}, 32'b100);
      axi_rvalid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ahb2axi_bridge.md
# ahb2axi_bridge

- AHB-Lite slave to AXI3 master bridge; the reverse direction of `axi2ahb_bridge`.
- Converts every accepted AHB transfer (NONSEQ or SEQ) into one single-beat AXI transaction and holds the AHB data phase with `ahb_hreadyout` low until the AXI response returns.
- Sits between an AHB subsystem and the AXI interconnect slave ports.
- Only one transaction is outstanding at a time; `ahb_hburst` is not used.

## Interface
- `AXI_ID`, default 8'h00: value driven on `axi_awid`, `axi_wid` and `axi_arid`.
- `W_ADDR`, default 32: address width. Data width is fixed at 32.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ahb_hsel` input 1: slave select.
- `ahb_haddr` input W_ADDR: AHB address.
- `ahb_htrans` input 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `ahb_hwrite` input 1: 1 = write.
- `ahb_hsize` input 3: transfer size.
- `ahb_hwdata` input 32: write data, valid in the data phase.
- `ahb_hready` input 1: bus-level HREADY.
- `ahb_hreadyout` output 1: this slave's ready.
- `ahb_hresp` output 2: 0 = OKAY, 1 = ERROR.
- `ahb_hrdata` output 32: read data.
- `axi_awid` / `axi_wid` / `axi_arid` output 8: always `AXI_ID`.
- `axi_awaddr` / `axi_araddr` output W_ADDR: registered `ahb_haddr`.
- `axi_awlen` / `axi_arlen` output 8: constant 0.
- `axi_awsize` / `axi_arsize` output 3: registered `ahb_hsize`.
- `axi_awburst` / `axi_arburst` output 2: constant 2'b01 (INCR).
- `axi_awvalid` output 1, `axi_awready` input 1: AW handshake.
- `axi_wdata` output 32: registered `ahb_hwdata`.
- `axi_wstrb` output 4: derived from the address and size (see Operation).
- `axi_wlast` output 1: 1 whenever `axi_wvalid` is 1.
- `axi_wvalid` output 1, `axi_wready` input 1: W handshake.
- `axi_bid` input 8: ignored.
- `axi_bresp` input 2: write response.
- `axi_bvalid` input 1, `axi_bready` output 1: B handshake.
- `axi_arvalid` output 1, `axi_arready` input 1: AR handshake.
- `axi_rid` input 8, `axi_rlast` input 1: ignored.
- `axi_rdata` input 32: read data.
- `axi_rresp` input 2: read response.
- `axi_rvalid` input 1, `axi_rready` output 1: R handshake.

## Operation
- **Accept condition.** A transfer is accepted when `ahb_hsel & ahb_htrans[1] & ahb_hready & ahb_hreadyout`.
  - On accept, register the address, write flag and size.
  - IDLE/BUSY, or a cycle with `ahb_hsel` low, gets a zero-wait OKAY and starts no AXI activity.
- **States:** IDLE, WDATA, WREQ, WRSP, RREQ, RRSP, DONE, ERR1, ERR2.
- **From IDLE (on accept):**
  - `ahb_hsize` > 2 → ERR1 (no AXI access).
  - Write → WDATA.
  - Read → RREQ.
- **WDATA.** Capture `ahb_hwdata` into the `axi_wdata` register; go to WREQ.
- **WREQ.**
  - Assert `axi_awvalid` and `axi_wvalid` together.
  - Each valid drops on its own handshake; AW and W may complete in different cycles.
  - When both have completed → WRSP.
- **WRSP.** `axi_bready`=1. On `axi_bvalid`: if `bresp[1]` is set → ERR1, else → DONE.
- **RREQ.** `axi_arvalid`=1 until `axi_arready`; then → RRSP.
- **RRSP.** `axi_rready`=1. On `axi_rvalid`: latch `axi_rdata` into `ahb_hrdata`; if `rresp[1]` is set → ERR1, else → DONE.
- **DONE.** `ahb_hreadyout`=1, `ahb_hresp`=OKAY. A new accept in this cycle is taken (pipelined address phase); otherwise → IDLE.
- **ERR1 → ERR2.** ERR1: `hreadyout`=0, `hresp`=ERROR. ERR2: `hreadyout`=1, `hresp`=ERROR. ERR2 accepts a new transfer like DONE.
- **wstrb:**
  - byte: `4'b0001 << haddr[1:0]`.
  - half: `4'b0011 << {haddr[1],1'b0}`.
  - word: `4'hF`.
- **EXOKAY** (2'b01) is treated as OKAY.

## Timing
- **Reset values:**
  - `ahb_hreadyout`=1, `ahb_hresp`=0, `ahb_hrdata`=0.
  - All AXI valid/ready outputs 0; `axi_awaddr`, `axi_araddr`, `axi_wdata`, `axi_wstrb` all 0.
  - State = IDLE.
- **Registered outputs:** every output is registered except the constants.
- **Accept cycle:** `ahb_hreadyout` falls in the cycle after the accept.
- **Write, zero-latency AXI:**
  - Cycle 1: WDATA.
  - Cycle 2: AW/W handshake.
  - Cycle 3: B handshake.
  - Cycle 4: `hreadyout`=1.
  - Result: 3 wait states.
- **Read, zero-latency AXI:**
  - Cycle 1: AR handshake.
  - Cycle 2: R handshake.
  - Cycle 3: `hreadyout`=1, `hrdata` valid.
  - Result: 2 wait states.
- **AXI valid stability:** an AXI valid never deasserts before its ready.
- **`axi_bvalid` / `axi_rvalid`:** ignored outside WRSP/RRSP.
- **Reset mid-transaction:** all outputs return to reset values immediately; the state returns to IDLE.

## Structure
- **Shared package `ahb_axi_pkg`:** HTRANS, HRESP, AXI BURST and RESP encodings, and the state enum.
- **Sub-module `ahb2axi_strb_gen`:** combinational `hsize`/`haddr` → `wstrb`.

## Test plan
- **Word write:** write 0x3100, data 0xDEADBEEF, AXI ready tied 1, `bresp`=0.
  - Required: `awaddr`=0x3100, `wdata`=0xDEADBEEF, `wstrb`=0xF, `wlast`=1.
  - Required: `hreadyout` low for exactly 3 cycles; `hresp`=OKAY.
- **Byte read:** byte read at 0x3202, `rdata`=0x00AB0000.
  - Required: `arsize`=0, `hrdata`=0x00AB0000, 2 wait states.
- **Staggered write channels:** `awready` delayed 3 cycles, `wready` delayed 1.
  - Required: `wvalid` drops after its own handshake while `awvalid` stays high.
  - Required: `bready` is asserted only after both handshakes complete.
- **Error responses:**
  - `bresp`=2'b10 → `hresp`=ERROR with `hreadyout`=0 then 1.
  - `hsize`=3 → the same two-cycle ERROR with no AXI valid asserted.
- **Back-to-back:** NONSEQ write then SEQ read, the second accepted in the DONE cycle.
  - Required: AR is issued without passing through IDLE.
  - Required: IDLE htrans gives a zero-wait OKAY.
- **Reset mid-transaction:** `rst_n` asserted while in WRSP.
  - Required: all outputs return to reset values immediately.
  - Required: after release, a new read completes normally.
